// File: rtl/select_max_unit.sv
// Sequential arg-max over N signed classifier scores: capture once, scan one
// element per clock, report the index of the largest score with a done flag.
module select_max_unit #(
    parameter int N     = 10,
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [W-1:0] in_data [0:N-1],
    output logic [IDX_W-1:0]    digit,
    output logic                layer_done
);

    // state | meaning
    // IDLE  | waiting for enable; captures in_data on the enabling edge
    // SCAN  | comparing one buffered score per clock against the running max
    // DONE  | result held on digit/layer_done until enable drops
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] buffer [0:N-1];
    logic signed [W-1:0] run_max;
    logic [IDX_W-1:0]    run_idx;
    logic [IDX_W-1:0]    ptr;
    logic signed [W-1:0] cand;
    logic                greater;
    logic                last;

    logic capture;
    logic step;
    logic finish;
    logic clear_done;

    generate
        if (N > 1) begin : g_multi
            assign cand = buffer[ptr];
        end else begin : g_single
            assign cand = buffer[0];
        end
    endgenerate

    // Strict compare so a tie keeps the earlier (lower) index.
    assign greater = (cand > run_max);
    assign last    = (N == 1) || (ptr == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture    = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        clear_done = 1'b0;
        case (state)
            IDLE: capture = enable;
            SCAN: begin
                step       = enable;
                finish     = enable && last;
                clear_done = !enable;
            end
            DONE: clear_done = !enable;
            default: clear_done = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                buffer[i] <= '0;
            end
            run_max    <= '0;
            run_idx    <= '0;
            ptr        <= '0;
            digit      <= '0;
            layer_done <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < N; i++) begin
                    buffer[i] <= in_data[i];
                end
                run_max <= in_data[0];
                run_idx <= '0;
                ptr     <= IDX_W'(1);
            end
            if (step) begin
                if (greater) begin
                    run_max <= cand;
                    run_idx <= ptr;
                end
                if (!last) begin
                    ptr <= ptr + IDX_W'(1);
                end
            end
            // The final compare is folded into the digit load so digit and
            // layer_done update on the same edge as the last element.
            if (finish) begin
                digit      <= greater ? ptr : run_idx;
                layer_done <= 1'b1;
            end
            if (clear_done) begin
                layer_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_select_max_unit.sv
// Table-driven bench for select_max_unit with a result scoreboard queue.
module tb_select_max_unit;

    localparam int N     = 10;
    localparam int W     = 8;
    localparam int IDX_W = 4;

    logic                clk;
    logic                reset;
    logic                enable;
    logic signed [W-1:0] in_data [0:N-1];
    logic [IDX_W-1:0]    digit;
    logic                layer_done;

    typedef struct {
        int data [0:N-1];
        int exp_digit;
    } vec_t;

    vec_t tbl [0:5];
    int   late_data [0:N-1];
    int   exp_q [$];
    int   n_vec;
    int   n_err;

    select_max_unit #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .digit      (digit),
        .layer_done (layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_vec(input int vi);
        for (int j = 0; j < N; j++) begin
            in_data[j] = W'(tbl[vi].data[j]);
        end
    endtask

    // Raises enable, waits for the result, checks latency/digit/stability,
    // and optionally drops enable for a single cycle afterwards.
    task automatic run_vec(input int vi, input bit release_en, input int change_at);
        int lat;
        int exp;
        bit seen;
        drive_vec(vi);
        enable = 1'b1;
        exp_q.push_back(tbl[vi].exp_digit);
        seen = 1'b0;
        lat  = -1;
        exp  = -1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (change_at != 0 && i == change_at) begin
                for (int j = 0; j < N; j++) begin
                    in_data[j] = W'(late_data[j]);
                end
            end
            if (layer_done) begin
                seen = 1'b1;
                lat  = i - 1;
            end
        end
        check("latency", lat, N - 1);
        if (seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp = exp_q.pop_front();
                check("digit", int'(digit), exp);
            end
        end else begin
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        check("hold_done", int'(layer_done), 1);
        if (exp >= 0) begin
            check("hold_digit", int'(digit), exp);
        end
        if (release_en) begin
            enable = 1'b0;
            @(negedge clk);
            check("release_done", int'(layer_done), 0);
            if (exp >= 0) begin
                check("release_digit", int'(digit), exp);
            end
        end
    endtask

    initial begin
        bit rose;
        n_vec = 0;
        n_err = 0;

        tbl[0].data = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
        tbl[0].exp_digit = 3;
        tbl[1].data = '{-5, -3, -3, -128, -1, -1, -7, -2, -9, -4};
        tbl[1].exp_digit = 4;
        tbl[2].data = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        tbl[2].exp_digit = 0;
        tbl[3].data = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
        tbl[3].exp_digit = 9;
        tbl[4].data = '{127, 126, 126, 126, 126, 126, 126, 126, 126, 126};
        tbl[4].exp_digit = 0;
        tbl[5].data = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        tbl[5].exp_digit = 9;
        late_data = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};

        reset  = 1'b1;
        enable = 1'b0;
        for (int j = 0; j < N; j++) begin
            in_data[j] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_digit", int'(digit), 0);
        check("reset_done", int'(layer_done), 0);
        reset = 1'b0;
        drive_vec(0);
        repeat (7) @(negedge clk);
        check("idle_done", int'(layer_done), 0);

        for (int v = 0; v < 5; v++) begin
            run_vec(v, 1'b1, 0);
        end

        // in_data rewritten after capture must not affect the result
        run_vec(0, 1'b1, 2);

        // abort on the 4th SCAN cycle
        drive_vec(3);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (layer_done) rose = 1'b1;
        end
        check("abort_done", int'(rose), 0);
        check("abort_digit", int'(digit), 3);

        run_vec(3, 1'b1, 0);

        // back-to-back with a single idle cycle between results
        run_vec(0, 1'b1, 0);
        run_vec(5, 1'b1, 0);

        // reset while holding a result
        run_vec(1, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_done_digit", int'(digit), 0);
        check("rst_done_flag", int'(layer_done), 0);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("post_rst_flag", int'(layer_done), 0);

        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/select_max_unit.md
# select_max_unit

Sequential arg-max block for the classifier output stage. It captures a vector of N signed scores from the final network layer and scans them one element per clock. It reports the index of the largest score as the recognised digit, plus a completion flag. It sits after the last dense layer and drives the digit result to the top level.

## Interface
- N, default 10: number of scores (class count).
- W, default 8: width of each signed score.
- IDX_W, default 4: width of the index output, equal to $clog2(N); must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  start/hold request; level-sensitive.
- in_data  input  W × [0:N-1]  unpacked array of signed two's-complement scores.
- digit  output  IDX_W  index of the maximum score (registered).
- layer_done  output  1  high while a valid result is held (registered).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE
  - If enable = 1 at a clock edge, copy all N in_data elements into an internal buffer.
  - Set running max = in_data[0], running index = 0, scan pointer = 1.
  - Go to SCAN.
  - Otherwise remain in IDLE.
- SCAN: compare buffer[pointer] against the running max using a signed comparison.
  - If it is strictly greater, replace the running max and index.
  - Ties keep the lower index.
  - When pointer = N-1: load digit with the final index, set layer_done = 1, go to DONE. Otherwise increment pointer.
- DONE
  - digit and layer_done hold while enable = 1.
  - When enable = 0, go to IDLE and clear layer_done. digit keeps its last value.
- Once captured, in_data changes during SCAN or DONE have no effect.
- Aborting a scan: enable = 0 during SCAN returns to IDLE with layer_done = 0 and digit unchanged.
- N = 1: the scan completes on the first SCAN cycle with digit = 0.

## Timing
- Reset (synchronous, dominates all other inputs): state = IDLE, digit = 0, layer_done = 0, buffer, running max and index cleared.
- Latency: with enable sampled high at edge k (IDLE→SCAN, capture), the compares occur at edges k+1 … k+N-1.
  - digit and layer_done update together at edge k+N-1.
  - For N = 10, layer_done rises 9 cycles after the capture edge.
- layer_done never rises without a full N-element scan.
- digit is only meaningful while layer_done = 1.
- Restart: after DONE→IDLE, a new capture needs enable high at a later edge; minimum 1 idle cycle between results.
- Reset asserted mid-scan: IDLE on that edge, outputs cleared, no result produced.

## Test plan
- Basic
  - Stimulus: reset low; in_data = {0,0,5,85,0,10,0,0,0,0}; enable raised after ~7 cycles and held.
  - Response: layer_done = 1 exactly 9 cycles after the capture edge; digit = 3; both stable for the rest of the enable window.
- Negatives and ties
  - Stimulus 1: in_data = {-5,-3,-3,-128,-1,-1,-7,-2,-9,-4}.
  - Response 1: digit = 4 (first of the tied maxima).
  - Stimulus 2: all elements = -128.
  - Response 2: digit = 0.
- Extremes at the boundaries
  - Stimulus 1: in_data[9] = 127, others 0.
  - Response 1: digit = 9.
  - Stimulus 2: in_data[0] = 127, others 126.
  - Response 2: digit = 0.
- Input change after capture
  - Stimulus: in_data changed to {0,0,0,0,0,0,0,0,0,100} two cycles after the capture edge.
  - Response: the result still reflects the captured vector (digit = 3 for the basic vector).
- Abort and reset
  - Stimulus 1: enable dropped on the 4th SCAN cycle.
  - Response 1: IDLE, layer_done stays 0.
  - Stimulus 2: re-enable.
  - Response 2: full 9-cycle scan, correct digit.
  - Stimulus 3: reset pulsed during DONE.
  - Response 3: digit = 0 and layer_done = 0 on the next edge.
- Back-to-back results
  - Stimulus: enable deasserted for one cycle after DONE, then reasserted with new data {1,2,3,4,5,6,7,8,9,10}.
  - Response: layer_done drops for at least one cycle, then rises with digit = 9.
